// File: rtl/uart_channel_controller_pkg.sv
// Shared constants for the UART command path.
// Instruction and channel encodings are the same values the UART decoder
// emits; the state types belong to the command FSM and to the receive lanes.
package uart_channel_controller_pkg;

  typedef enum logic [2:0] {
    UART_NOP   = 3'b000,
    UART_TELL  = 3'b001,
    UART_READ  = 3'b010,
    UART_WRITE = 3'b011
  } uart_instr_e;

  localparam logic UART_CH_A = 1'b0;
  localparam logic UART_CH_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_START,
    ST_TX_DATA,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_FINISH
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // TELL and WRITE both drive a frame onto the selected TX line.
  function automatic logic is_tx_instr(input logic [2:0] instr);
    return (instr == UART_TELL) || (instr == UART_WRITE);
  endfunction

endpackage

// File: rtl/uart_rx_lane.sv
// One free-running 8N1 receive lane with a one-byte holding register.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_rx             asynchronous serial input, idle high
//   i_consume        holding register is read this cycle (invalidate it)
//   i_bypass         a READ is waiting: a good byte is handed out, not stored
//   i_clr_flags      clear sticky overrun/frame flags
//   o_byte_stb       one-cycle pulse for a good received byte
//   o_byte           the byte accompanying o_byte_stb
//   o_valid, o_data  holding register state and contents
//   o_overrun        sticky: good byte lost because the register was full
//   o_frame_err      sticky: stop bit sampled low
module uart_rx_lane
  import uart_channel_controller_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_consume,
  input  logic       i_bypass,
  input  logic       i_clr_flags,
  output logic       o_byte_stb,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_overrun,
  output logic       o_frame_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e   r_state;
  rx_state_e   w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [TW-1:0] r_timer;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_hold;
  logic        r_valid;
  logic        r_overrun;
  logic        r_frame_err;

  logic w_fall;
  logic w_half;
  logic w_full;
  logic w_stop_sample;
  logic w_good;
  logic w_bad_stop;

  assign w_fall        = r_prev & ~r_sync2;
  assign w_half        = (r_timer == HALF_LAST);
  assign w_full        = (r_timer == BIT_LAST);
  assign w_stop_sample = (r_state == RX_STOP) && w_full;
  assign w_good        = w_stop_sample & r_sync2;
  assign w_bad_stop    = w_stop_sample & ~r_sync2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      // Start bit re-checked half a bit in; a high line was a glitch.
      RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && (r_bit_idx == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if ((r_state == RX_IDLE) || (w_next != r_state) || w_full) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      if (r_state == RX_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == RX_DATA) && w_full) begin
        r_shift   <= {r_sync2, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (i_clr_flags) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_bad_stop) begin
        r_frame_err <= 1'b1;
      end

      if (i_consume) begin
        r_valid <= 1'b0;
      end
      // A byte consumed in the same cycle frees the slot for the new one.
      if (w_good && !i_bypass) begin
        if (r_valid && !i_consume) begin
          r_overrun <= 1'b1;
        end else begin
          r_hold  <= r_shift;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_byte_stb  = w_good;
  assign o_byte      = r_shift;
  assign o_valid     = r_valid;
  assign o_data      = r_hold;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_channel_controller.sv
// Executes decoded UART commands on channels A and B.
// One shared 8N1 transmitter is muxed onto the selected channel; two
// always-running receive lanes buffer one byte each.
// Ports:
//   CLK, RESET_N             clock, asynchronous active-low reset
//   UART_START               command strobe, honoured only when idle
//   UART_channel             0 = A, 1 = B
//   UART_instr               NOP / TELL / READ / WRITE (others act as NOP)
//   UART_code_value          TELL byte or READ timeout code (0 = no timeout)
//   UART_write_value         WRITE byte
//   RX_A, RX_B / TX_A, TX_B  serial lines, idle high
//   UART_BUSY, UART_DONE     command in progress / one-cycle completion
//   UART_READ_DATA           byte from the last successful READ
//   UART_TIMEOUT             last READ ended without data
//   UART_OVERRUN             sticky per channel, cleared by a READ on it
//   UART_FRAME_ERR           sticky per channel, cleared by a READ on it
module uart_channel_controller
  import uart_channel_controller_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned TIMEOUT_SHIFT = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       UART_START,
  input  logic       UART_channel,
  input  logic [2:0] UART_instr,
  input  logic [7:0] UART_code_value,
  input  logic [7:0] UART_write_value,
  input  logic       RX_A,
  input  logic       RX_B,
  output logic       TX_A,
  output logic       TX_B,
  output logic       UART_BUSY,
  output logic       UART_DONE,
  output logic [7:0] UART_READ_DATA,
  output logic       UART_TIMEOUT,
  output logic [1:0] UART_OVERRUN,
  output logic [1:0] UART_FRAME_ERR
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TL = 8 + TIMEOUT_SHIFT;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  ctrl_state_e  r_state;
  ctrl_state_e  w_next;
  logic         r_chan;
  logic [2:0]   r_instr;
  logic [7:0]   r_shift;
  logic [TW-1:0] r_timer;
  logic [2:0]   r_bit_idx;
  logic         r_tx;
  logic [TL-1:0] r_tmo_limit;
  logic [TL-1:0] r_tmo_cnt;
  logic [7:0]   r_read_data;
  logic         r_timeout;

  logic            w_accept;
  logic            w_bit_done;
  logic            w_tmo_hit;
  logic            w_sel_valid;
  logic            w_wait_stb;
  logic [1:0]      w_rx_valid;
  logic [1:0]      w_rx_stb;
  logic [1:0][7:0] w_rx_byte;
  logic [1:0][7:0] w_rx_data;
  logic [1:0]      w_consume;
  logic [1:0]      w_bypass;
  logic [1:0]      w_clr;

  assign w_accept    = UART_START && (r_state == ST_IDLE);
  assign w_bit_done  = (r_timer == BIT_LAST);
  assign w_sel_valid = w_rx_valid[UART_channel];
  assign w_wait_stb  = w_rx_stb[r_chan];
  // Zero limit means wait forever.
  assign w_tmo_hit   = (r_tmo_limit != '0) && (r_tmo_cnt == (r_tmo_limit - TL'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_tx_instr(UART_instr)) begin
            w_next = ST_TX_START;
          end else if (UART_instr == UART_READ) begin
            w_next = w_sel_valid ? ST_FINISH : ST_RX_WAIT;
          end else begin
            w_next = ST_FINISH;
          end
        end
      end
      ST_TX_START: if (w_bit_done) w_next = ST_TX_DATA;
      ST_TX_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_next = ST_TX_STOP;
      ST_TX_STOP:  if (w_bit_done) w_next = ST_FINISH;
      ST_RX_WAIT:  if (w_wait_stb || w_tmo_hit) w_next = ST_FINISH;
      ST_FINISH:   w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_consume = '0;
    w_bypass  = '0;
    w_clr     = '0;
    if (w_accept && (UART_instr == UART_READ)) begin
      w_consume[UART_channel] = w_sel_valid;
    end
    if (r_state == ST_RX_WAIT) begin
      w_bypass[r_chan] = 1'b1;
    end
    if ((r_state == ST_FINISH) && (r_instr == UART_READ)) begin
      w_clr[r_chan] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_chan      <= UART_CH_A;
      r_instr     <= UART_NOP;
      r_shift     <= '0;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_tx        <= 1'b1;
      r_tmo_limit <= '0;
      r_tmo_cnt   <= '0;
      r_read_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (((r_state == ST_TX_START) || (r_state == ST_TX_DATA) ||
           (r_state == ST_TX_STOP)) && !w_bit_done) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end

      if (w_accept) begin
        r_chan      <= UART_channel;
        r_instr     <= UART_instr;
        r_timeout   <= 1'b0;
        r_shift     <= (UART_instr == UART_WRITE) ? UART_write_value : UART_code_value;
        r_tmo_limit <= TL'(UART_code_value) << TIMEOUT_SHIFT;
        r_tmo_cnt   <= '0;
        if (is_tx_instr(UART_instr)) begin
          r_tx <= 1'b0;
        end
        if ((UART_instr == UART_READ) && w_sel_valid) begin
          r_read_data <= w_rx_data[UART_channel];
        end
      end

      case (r_state)
        ST_TX_START: begin
          if (w_bit_done) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= '0;
          end
        end
        ST_TX_DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_RX_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TL'(1);
          // An arriving byte beats a coincident timeout.
          if (w_wait_stb) begin
            r_read_data <= w_rx_byte[r_chan];
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_rx_lane #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_a (
    .i_clk       (CLK),
    .i_rst_n     (RESET_N),
    .i_rx        (RX_A),
    .i_consume   (w_consume[0]),
    .i_bypass    (w_bypass[0]),
    .i_clr_flags (w_clr[0]),
    .o_byte_stb  (w_rx_stb[0]),
    .o_byte      (w_rx_byte[0]),
    .o_valid     (w_rx_valid[0]),
    .o_data      (w_rx_data[0]),
    .o_overrun   (UART_OVERRUN[0]),
    .o_frame_err (UART_FRAME_ERR[0])
  );

  uart_rx_lane #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_b (
    .i_clk       (CLK),
    .i_rst_n     (RESET_N),
    .i_rx        (RX_B),
    .i_consume   (w_consume[1]),
    .i_bypass    (w_bypass[1]),
    .i_clr_flags (w_clr[1]),
    .o_byte_stb  (w_rx_stb[1]),
    .o_byte      (w_rx_byte[1]),
    .o_valid     (w_rx_valid[1]),
    .o_data      (w_rx_data[1]),
    .o_overrun   (UART_OVERRUN[1]),
    .o_frame_err (UART_FRAME_ERR[1])
  );

  assign TX_A           = (r_chan == UART_CH_A) ? r_tx : 1'b1;
  assign TX_B           = (r_chan == UART_CH_B) ? r_tx : 1'b1;
  assign UART_BUSY      = (r_state != ST_IDLE);
  assign UART_DONE      = (r_state == ST_FINISH);
  assign UART_READ_DATA = r_read_data;
  assign UART_TIMEOUT   = r_timeout;

endmodule
